// File: rtl/shbus_deserializer_pkg.sv
// Shared definitions for the share-bus deserializer and its beat counter:
// beat-count helpers and the two-state collection encoding.
package shbus_deserializer_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    // Beats per full value.
    function automatic int calc_nb(input int count, input int word);
        return count / word;
    endfunction

    // Counter width max(1, clog2(nb)); a single-beat value still needs one bit.
    function automatic int calc_cnt_w(input int nb);
        int w;
        w = $clog2(nb);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/shbus_beat_counter.sv
// Beat position counter: counts accepted beats 0..NB-1 and wraps, flagging the
// final beat of a value. Shared with the matching serializer.
module shbus_beat_counter
    import shbus_deserializer_pkg::*;
#(
    parameter int NB    = 4,
    parameter int CNT_W = calc_cnt_w(NB)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             is_last
);

    logic [CNT_W-1:0] r_cnt;

    assign is_last = (r_cnt == CNT_W'(NB - 1));
    assign cnt     = r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (is_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/shbus_deserializer.sv
// Gathers word-wide share-bus beats into one d*count share-bus value and hands
// it downstream over valid/ready. Only moves wires; shares are never combined.
module shbus_deserializer
    import shbus_deserializer_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 128,
    parameter int word  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [d*word-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [d*count-1:0] out_data,
    output logic               err
);

    localparam int NB      = calc_nb(count, word);
    localparam int CNT_W   = calc_cnt_w(NB);
    localparam int SLICE_W = d * word;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [d*count-1:0] r_data;
    logic               r_err;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_is_last;
    logic               w_accept;
    logic               w_take;

    assign out_valid = (r_state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_take    = out_valid && out_ready;
    assign out_data  = r_data;
    assign err       = r_err;

    // An accept while FULL implies a take, so the counter sits at 0 and the
    // beat lands in slice 0; the counter needs no knowledge of the state.
    shbus_beat_counter #(
        .NB    (NB),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_accept),
        .cnt     (w_cnt),
        .is_last (w_is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_is_last ? FULL : COLLECT;
        end else if (w_take) begin
            w_state_nxt = COLLECT;
        end
    end

    // NOTE: the assembly register is reset because a cleared bus after reset is
    // part of the interface contract, unlike a plain storage array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (w_accept && (w_cnt == CNT_W'(k))) begin
                    r_data[k*SLICE_W +: SLICE_W] <= in_data;
                end
            end
        end
    end

    // in_last is only cross-checked against the counter; it never moves data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && (in_last != w_is_last);
        end
    end

endmodule

// File: tb/tb_shbus_deserializer.sv
// Scoreboard bench for shbus_deserializer: NB=4 main instance plus an NB=1
// instance for the one-value-per-cycle streaming case.
module tb_shbus_deserializer;

    localparam int BW = 64;
    localparam int VW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [BW-1:0] in_data;
    logic          out_valid, out_ready, err;
    logic [VW-1:0] out_data;

    logic          in_valid1, in_ready1, in_last1;
    logic [BW-1:0] in_data1;
    logic          out_valid1, out_ready1, err1;
    logic [BW-1:0] out_data1;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [VW-1:0] sb_q[$];

    always #5 clk = ~clk;

    shbus_deserializer #(.d(2), .count(128), .word(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    shbus_deserializer #(.d(2), .count(32), .word(32)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .in_last   (in_last1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .err       (err1)
    );

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat(input logic [7:0] v, input logic [7:0] k);
        return {v, k, 16'hBEEF, k, v, 16'h1234};
    endfunction

    function automatic logic [VW-1:0] value_of(input logic [7:0] v);
        return {beat(v, 8'd3), beat(v, 8'd2), beat(v, 8'd1), beat(v, 8'd0)};
    endfunction

    // Monitor: every completed output handshake is compared against the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_output: got %h with no value expected", out_data);
            end else begin
                check("out_data", out_data, sb_q.pop_front());
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [BW-1:0] data, input logic last, input logic exp_err);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("err", err, exp_err);
    endtask

    task automatic send_value(input logic [7:0] v);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) sb_q.push_back(value_of(v));
            send_beat(beat(v, 8'(k)), (k == 3), 1'b0);
            if (k == 2) check("out_valid_early", out_valid, 1'b0);
        end
        check("out_valid_latency", out_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_data1   = '0;
        in_last1   = 1'b0;
        out_ready1 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_err", err, 1'b0);
        check("rst_out_data", out_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back value, downstream always ready.
        send_value(8'h01);
        @(negedge clk);
        check("out_valid_after_take", out_valid, 1'b0);

        // Backpressure: value held for 10 cycles.
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        send_value(8'h02);
        for (int i = 0; i < 10; i++) begin
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_out_data", out_data, value_of(8'h02));
            @(negedge clk);
        end

        // Release while beat 0 of the next value waits: both handshakes at once.
        fork
            send_beat(beat(8'h03, 8'd0), 1'b0, 1'b0);
            begin
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("overlap_cnt", u_dut.w_cnt, 2'd1);
        check("overlap_out_valid", out_valid, 1'b0);

        // Remaining beats with 3 idle cycles before each.
        for (int k = 1; k < 4; k++) begin
            repeat (3) @(negedge clk);
            if (k == 3) sb_q.push_back(value_of(8'h03));
            send_beat(beat(8'h03, 8'(k)), (k == 3), 1'b0);
            if (k == 2) check("gap_out_valid_early", out_valid, 1'b0);
        end
        check("gap_out_valid_latency", out_valid, 1'b1);
        @(negedge clk);

        // in_last on the wrong beats: err after beat 1 and after beat 3.
        send_beat(beat(8'h04, 8'd0), 1'b0, 1'b0);
        send_beat(beat(8'h04, 8'd1), 1'b1, 1'b1);
        send_beat(beat(8'h04, 8'd2), 1'b0, 1'b0);
        sb_q.push_back(value_of(8'h04));
        send_beat(beat(8'h04, 8'd3), 1'b0, 1'b1);
        check("err_value_out_valid", out_valid, 1'b1);
        @(negedge clk);
        check("err_clears", err, 1'b0);

        // Reset mid-value discards the partial collection.
        send_beat(beat(8'h05, 8'd0), 1'b0, 1'b0);
        send_beat(beat(8'h05, 8'd1), 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_value(8'h06);
        @(negedge clk);

        // NB=1 instance: a new value every cycle.
        in_valid1 = 1'b1;
        in_last1  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data1 = beat(8'h70 + 8'(i), 8'(i));
            @(negedge clk);
            check("nb1_out_valid", out_valid1, 1'b1);
            check("nb1_out_data", out_data1, beat(8'h70 + 8'(i), 8'(i)));
            check("nb1_err", err1, 1'b0);
        end
        in_valid1 = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
